// File: rtl/cpu_step_ctrl.sv
// Run/single-step controller: turns a bouncing step button and a run switch
// into a one-cycle tick enable for the CPU, with a sticky halt.
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int DIV_W      = 4
) (
    input  logic             in,
    input  logic             rst,
    input  logic             btn,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             halt,
    output logic             tick,
    output logic             btn_db,
    output logic [1:0]       state,
    output logic [15:0]      step_cnt
);

    localparam int DC_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d;
    logic              btn_db_q, btn_db_d;
    logic              db_prev_q, db_prev_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [DIV_W-1:0]  rc_q, rc_d;
    logic              tick_q, tick_d;
    logic [15:0]       step_cnt_q, step_cnt_d;

    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        btn_db_d  = btn_db_q;
        dc_d      = dc_q;
        db_prev_d = btn_db_q;

        // Debounce keeps running in every state, including HALT.
        if (s2_q == btn_db_q) begin
            dc_d = '0;
        end else if (dc_q == DC_MAX) begin
            btn_db_d = s2_q;
            dc_d     = '0;
        end else begin
            dc_d = dc_q + 1'b1;
        end

        state_d = state_q;
        if (halt) begin
            state_d = HALT;
        end else begin
            case (state_q)
                IDLE:    if (run)  state_d = RUN;
                RUN:     if (!run) state_d = IDLE;
                default: state_d = HALT;
            endcase
        end

        // Any state change clears the divider and drops a tick due on this edge.
        tick_d = 1'b0;
        rc_d   = '0;
        case (state_q)
            IDLE: begin
                if (state_d == IDLE && btn_db_q && !db_prev_q) tick_d = 1'b1;
            end
            RUN: begin
                if (state_d == RUN) begin
                    if (rc_q == div) begin
                        tick_d = 1'b1;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        step_cnt_d = step_cnt_q + {15'b0, tick_d};
    end

    always_ff @(posedge in) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            btn_db_q   <= 1'b0;
            db_prev_q  <= 1'b0;
            dc_q       <= '0;
            rc_q       <= '0;
            tick_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            btn_db_q   <= btn_db_d;
            db_prev_q  <= db_prev_d;
            dc_q       <= dc_d;
            rc_q       <= rc_d;
            tick_q     <= tick_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign tick     = tick_q;
    assign btn_db   = btn_db_q;
    assign state    = state_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEB_CYCLES=4, DIV_W=4.
module tb_cpu_step_ctrl;

    logic        in;
    logic        rst;
    logic        btn;
    logic        run;
    logic [3:0]  div;
    logic        halt;
    logic        tick;
    logic        btn_db;
    logic [1:0]  state;
    logic [15:0] step_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_step_ctrl #(.DEB_CYCLES(4), .DIV_W(4)) dut (
        .in(in), .rst(rst), .btn(btn), .run(run), .div(div), .halt(halt),
        .tick(tick), .btn_db(btn_db), .state(state), .step_cnt(step_cnt)
    );

    initial in = 1'b0;
    always #5 in = ~in;

    task automatic edge1();
        @(posedge in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = 1'b0; run = 1'b0; halt = 1'b0; div = 4'd0;
        edge1();
        edge1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b1; run = 1'b1; halt = 1'b0; div = 4'd0;
        edge1();
        edge1();
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_cmp++; if (btn_db !== 1'b0) begin n_bad++; $display("FAIL reset_btn_db: got %b want 0", btn_db); end
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", state); end
        n_cmp++; if (step_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_step_cnt: got %0d want 0", step_cnt); end
        do_reset();
    endtask

    task automatic test_single_step();
        logic exp_db, exp_tick;
        do_reset();
        btn = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            edge1();
            exp_db   = (e >= 5 && e <= 16);
            exp_tick = (e == 6);
            n_cmp++; if (btn_db !== exp_db) begin n_bad++; $display("FAIL step_btn_db@%0d: got %b want %b", e, btn_db, exp_db); end
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL step_tick@%0d: got %b want %b", e, tick, exp_tick); end
            if (e == 11) btn = 1'b0;
        end
        n_cmp++; if (step_cnt !== 16'd1) begin n_bad++; $display("FAIL step_cnt: got %0d want 1", step_cnt); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            btn = ((c / 2) % 2 == 0);
            edge1();
            n_cmp++; if (btn_db !== 1'b0) begin n_bad++; $display("FAIL bounce_btn_db@%0d: got %b want 0", c, btn_db); end
            n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL bounce_tick@%0d: got %b want 0", c, tick); end
        end
        btn = 1'b0;
        for (int c = 0; c < 8; c++) begin
            edge1();
            n_cmp++; if (btn_db !== 1'b0 || tick !== 1'b0) begin n_bad++; $display("FAIL bounce_settle@%0d: got db=%b tick=%b want 0/0", c, btn_db, tick); end
        end
        n_cmp++; if (step_cnt !== 16'd0) begin n_bad++; $display("FAIL bounce_step_cnt: got %0d want 0", step_cnt); end
    endtask

    task automatic test_run_rate();
        int   nt;
        logic exp_tick;
        do_reset();
        run = 1'b1; div = 4'd3;
        edge1();
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL run_state: got %b want 01", state); end
        nt = 0;
        for (int k = 1; k <= 20; k++) begin
            edge1();
            exp_tick = (k % 4 == 0);
            if (tick === 1'b1) nt++;
            n_cmp++; if (tick !== exp_tick) begin n_bad++; $display("FAIL run_div3_tick@%0d: got %b want %b", k, tick, exp_tick); end
        end
        n_cmp++; if (nt != 5) begin n_bad++; $display("FAIL run_div3_count: got %0d want 5", nt); end
        div = 4'd0;
        for (int k = 21; k <= 28; k++) begin
            edge1();
            n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL run_div0_tick@%0d: got %b want 1", k, tick); end
        end
        n_cmp++; if (step_cnt !== 16'd13) begin n_bad++; $display("FAIL run_step_cnt: got %0d want 13", step_cnt); end
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge1();
            n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL run_stop_tick@%0d: got %b want 0", k, tick); end
            n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL run_stop_state@%0d: got %b want 00", k, state); end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        run = 1'b1; div = 4'd0;
        edge1();
        edge1();
        edge1();
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL midrun_tick_before: got %b want 1", tick); end
        rst = 1'b1;
        edge1();
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL midrun_tick: got %b want 0", tick); end
        n_cmp++; if (step_cnt !== 16'd0) begin n_bad++; $display("FAIL midrun_step_cnt: got %0d want 0", step_cnt); end
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL midrun_state: got %b want 00", state); end
        rst = 1'b0; run = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; div = 4'd2;
        edge1();
        edge1();
        edge1();
        halt = 1'b1;
        edge1();
        halt = 1'b0;
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL halt_state: got %b want 10", state); end
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL halt_tick: got %b want 0", tick); end
        n_cmp++; if (step_cnt !== 16'd0) begin n_bad++; $display("FAIL halt_step_cnt: got %0d want 0", step_cnt); end
        btn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 0) run = ~run;
            edge1();
            n_cmp++; if (tick !== 1'b0 || state !== 2'b10) begin n_bad++; $display("FAIL halt_hold@%0d: got tick=%b state=%b want 0/10", c, tick, state); end
        end
        n_cmp++; if (btn_db !== 1'b1) begin n_bad++; $display("FAIL halt_btn_db: got %b want 1", btn_db); end
        n_cmp++; if (step_cnt !== 16'd0) begin n_bad++; $display("FAIL halt_frozen_cnt: got %0d want 0", step_cnt); end
        rst = 1'b1;
        edge1();
        rst = 1'b0; btn = 1'b0; run = 1'b0;
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL halt_exit_state: got %b want 00", state); end
    endtask

    task automatic test_wrap();
        int glitches;
        do_reset();
        run = 1'b1; div = 4'd0;
        edge1();
        glitches = 0;
        for (int k = 1; k <= 65536; k++) begin
            edge1();
            if (tick !== 1'b1) glitches++;
            if (k == 65535) begin
                n_cmp++; if (step_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_ffff: got %0h want ffff", step_cnt); end
            end
        end
        n_cmp++; if (glitches != 0) begin n_bad++; $display("FAIL wrap_glitch: got %0d gaps want 0", glitches); end
        n_cmp++; if (step_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_step_cnt: got %0h want 0", step_cnt); end
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; run = 1'b0; halt = 1'b0; div = 4'd0;
        test_reset();
        test_single_step();
        test_bounce();
        test_run_rate();
        test_reset_midrun();
        test_halt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
